// File: rtl/fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_decode                                                 |
// | Description : In-order front end: PC, instruction fetch, decode and the    |
// |               integer/float register files. Optional REGFILE_BYPASS_EN     |
// |               forwards same-cycle writeback data to operand reads.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_decode #(
    parameter int          IMEM_AW  = 15,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rstn,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               enable,
    output logic [5:0]         opecode,
    output logic [4:0]         rd_no,
    output logic [4:0]         rs_no,
    output logic [4:0]         rt_no,
    output logic [15:0]        offset,
    output logic [31:0]        pc,
    output logic [31:0]        rs,
    output logic [31:0]        rt,
    output logic               fmode1,
    output logic               fmode2,
    input  logic               stop,
    input  logic               done,
    input  logic               pcenable,
    input  logic [31:0]        next_pc,
    input  logic               wenable,
    input  logic               wfmode,
    input  logic [4:0]         wreg,
    input  logic [31:0]        wdata,
    output logic               halted
);

    localparam logic [5:0] c_INST_J    = 6'h02;
    localparam logic [5:0] c_INST_ITOF = 6'h30;
    localparam logic [5:0] c_INST_FTOI = 6'h11;

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_ISSUE  = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_HALT   = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic        r_fmode1;
    logic        r_fmode2;
    logic [31:0] r_xreg [32];
    logic [31:0] r_freg [32];

    logic [31:0] w_src_inst;
    logic [5:0]  w_src_op;
    logic [4:0]  w_rs_idx;
    logic [4:0]  w_rt_idx;
    logic        w_fm1;
    logic        w_fm2;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_halt_target;
    logic        w_halt_hit;

    // DECODE reads operands straight from the BRAM word; ISSUE re-reads from the latched copy.
    assign w_src_inst = (r_state == c_ST_DECODE) ? imem_rdata : r_ir;
    assign w_src_op   = w_src_inst[31:26];
    assign w_rs_idx   = w_src_inst[20:16];
    assign w_rt_idx   = w_src_inst[15:11];
    assign w_fm2      = w_src_op[5];

    always_comb begin
        w_fm1 = w_src_op[5];
        if (w_src_op == c_INST_ITOF) begin
            w_fm1 = 1'b0;
        end else if (w_src_op == c_INST_FTOI) begin
            w_fm1 = 1'b1;
        end
    end

    always_comb begin
        w_rs_val = w_fm1 ? r_freg[w_rs_idx] : r_xreg[w_rs_idx];
        w_rt_val = w_fm2 ? r_freg[w_rt_idx] : r_xreg[w_rt_idx];
`ifdef REGFILE_BYPASS_EN
        if (wenable && (wfmode == w_fm1) && (wreg == w_rs_idx)) begin
            w_rs_val = wdata;
        end
        if (wenable && (wfmode == w_fm2) && (wreg == w_rt_idx)) begin
            w_rt_val = wdata;
        end
`endif
        // r0 override comes last so it also wins over any forwarded write.
        if (!w_fm1 && (w_rs_idx == 5'd0)) begin
            w_rs_val = '0;
        end
        if (!w_fm2 && (w_rt_idx == 5'd0)) begin
            w_rt_val = '0;
        end
    end

    assign w_halt_target = {4'h0, imem_rdata[25:0], 2'b00};
    assign w_halt_hit    = (imem_rdata[31:26] == c_INST_J) && (w_halt_target == r_pc);

    always_ff @(posedge clk) begin
        if (wenable) begin
            if (wfmode) begin
                r_freg[wreg] <= wdata;
            end else if (wreg != 5'd0) begin
                r_xreg[wreg] <= wdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_FETCH:  w_next_state = c_ST_DECODE;
            c_ST_DECODE: w_next_state = w_halt_hit ? c_ST_HALT : c_ST_ISSUE;
            c_ST_ISSUE:  w_next_state = stop ? c_ST_ISSUE : c_ST_WAIT;
            c_ST_WAIT:   w_next_state = done ? c_ST_FETCH : c_ST_WAIT;
            c_ST_HALT:   w_next_state = c_ST_HALT;
            default:     w_next_state = c_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= c_ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= {c_INST_J, 26'd0};
            r_rs     <= '0;
            r_rt     <= '0;
            r_fmode1 <= 1'b0;
            r_fmode2 <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_DECODE: begin
                    r_ir     <= imem_rdata;
                    r_rs     <= w_rs_val;
                    r_rt     <= w_rt_val;
                    r_fmode1 <= w_fm1;
                    r_fmode2 <= w_fm2;
                end
                c_ST_ISSUE: begin
                    if (stop) begin
                        r_rs <= w_rs_val;
                        r_rt <= w_rt_val;
                    end
                end
                c_ST_WAIT: begin
                    if (done) begin
                        r_pc <= pcenable ? next_pc : (r_pc + 32'd4);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr = r_pc[IMEM_AW+1:2];
    assign enable    = (r_state == c_ST_ISSUE);
    assign halted    = (r_state == c_ST_HALT);
    assign opecode   = r_ir[31:26];
    assign rd_no     = r_ir[25:21];
    assign rs_no     = r_ir[20:16];
    assign rt_no     = r_ir[15:11];
    assign offset    = r_ir[15:0];
    assign pc        = r_pc;
    assign rs        = r_rs;
    assign rt        = r_rt;
    assign fmode1    = r_fmode1;
    assign fmode2    = r_fmode2;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_decode                                              |
// | Description : Directed plus random bench for fetch_decode with a           |
// |               transaction-level register-file and PC model.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_decode;

    localparam int          AW      = 15;
    localparam logic [31:0] RST_PC  = 32'h0;
    localparam logic [5:0]  OP_J    = 6'h02;
    localparam logic [5:0]  OP_ITOF = 6'h30;
    localparam logic [5:0]  OP_FTOI = 6'h11;
    localparam logic [5:0]  OP_ADDI = 6'h08;
    localparam logic [5:0]  OP_FADD = 6'h20;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          enable;
    logic [5:0]    opecode;
    logic [4:0]    rd_no;
    logic [4:0]    rs_no;
    logic [4:0]    rt_no;
    logic [15:0]   offset;
    logic [31:0]   pc;
    logic [31:0]   rs;
    logic [31:0]   rt;
    logic          fmode1;
    logic          fmode2;
    logic          stop;
    logic          done;
    logic          pcenable;
    logic [31:0]   next_pc;
    logic          wenable;
    logic          wfmode;
    logic [4:0]    wreg;
    logic [31:0]   wdata;
    logic          halted;

    fetch_decode #(.IMEM_AW(AW), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .enable(enable), .opecode(opecode), .rd_no(rd_no), .rs_no(rs_no),
        .rt_no(rt_no), .offset(offset), .pc(pc), .rs(rs), .rt(rt),
        .fmode1(fmode1), .fmode2(fmode2), .stop(stop), .done(done),
        .pcenable(pcenable), .next_pc(next_pc), .wenable(wenable),
        .wfmode(wfmode), .wreg(wreg), .wdata(wdata), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [0:(1<<AW)-1];
    always @(posedge clk) imem_rdata <= imem[imem_addr];

    logic [31:0] mx [32];
    logic [31:0] mf [32];
    logic [31:0] mpc;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic mfm1(input logic [5:0] op);
        if (op == OP_ITOF) return 1'b0;
        if (op == OP_FTOI) return 1'b1;
        return op[5];
    endfunction

    // Value a read of (file, index) should return given the write currently being driven.
    function automatic logic [31:0] mread(input logic f, input logic [4:0] i);
        if (!f && i == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wenable && wfmode == f && wreg == i) return wdata;
`endif
        return f ? mf[i] : mx[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (wenable) begin
            if (wfmode) mf[wreg] = wdata;
            else if (wreg != 5'd0) mx[wreg] = wdata;
        end
        #1;
    endtask

    task automatic rand_wr(input bit en);
        wenable = en ? 1'($urandom_range(0, 1)) : 1'b0;
        wfmode  = 1'($urandom_range(0, 1));
        wreg    = 5'($urandom_range(0, 31));
        wdata   = $urandom;
    endtask

    task automatic check_fields(input string tag, input logic [31:0] inst, input logic f1, input logic f2);
        chk({tag, "_op"},   opecode, inst[31:26]);
        chk({tag, "_rd"},   rd_no,   inst[25:21]);
        chk({tag, "_rsno"}, rs_no,   inst[20:16]);
        chk({tag, "_rtno"}, rt_no,   inst[15:11]);
        chk({tag, "_off"},  offset,  inst[15:0]);
        chk({tag, "_pc"},   pc,      mpc);
        chk({tag, "_rs"},   rs,      e_rs);
        chk({tag, "_rt"},   rt,      e_rt);
        chk({tag, "_fm1"},  fmode1,  f1);
        chk({tag, "_fm2"},  fmode2,  f2);
    endtask

    // Entered in the FETCH cycle; leaves in the first WAIT cycle.
    task automatic do_issue(input int nstop, input bit rw, input bit fw, input logic fwf,
                            input logic [4:0] fwr, input logic [31:0] fwd, input bit late);
        logic [31:0] inst;
        logic        f1;
        logic        f2;
        inst = imem[mpc[AW+1:2]];
        f1   = mfm1(inst[31:26]);
        f2   = inst[31];
        chk("fetch_addr", imem_addr, mpc[AW+1:2]);
        chk("fetch_en", enable, 1'b0);
        rand_wr(rw);
        done = 1'($urandom_range(0, 1)); pcenable = 1'($urandom_range(0, 1)); next_pc = $urandom;
        tick();
        chk("decode_en", enable, 1'b0);
        rand_wr(rw);
        if (fw) begin wenable = 1'b1; wfmode = fwf; wreg = fwr; wdata = fwd; end
        e_rs = mread(f1, inst[20:16]);
        e_rt = mread(f2, inst[15:11]);
        tick();
        chk("issue_en", enable, 1'b1);
        check_fields("issue", inst, f1, f2);
        for (int k = 0; k < nstop; k++) begin
            stop = 1'b1;
            done = 1'($urandom_range(0, 1));
            rand_wr(rw);
            if (late && k == 0) begin
                wenable = 1'b1; wfmode = f1; wreg = inst[20:16]; wdata = $urandom;
            end
            e_rs = mread(f1, inst[20:16]);
            e_rt = mread(f2, inst[15:11]);
            tick();
            chk("stop_en", enable, 1'b1);
            check_fields("stop", inst, f1, f2);
        end
        stop = 1'b0;
        done = 1'($urandom_range(0, 1));
        rand_wr(rw);
        tick();
        chk("wait_en", enable, 1'b0);
        done = 1'b0; pcenable = 1'b0; wenable = 1'b0;
    endtask

    // Entered in WAIT; leaves in the FETCH cycle after done.
    task automatic do_done(input int idle, input bit pcen, input logic [31:0] npc, input bit we,
                           input logic wf, input logic [4:0] wr, input logic [31:0] wd, input bit rw);
        for (int k = 0; k < idle; k++) begin
            done = 1'b0; pcenable = 1'($urandom_range(0, 1)); next_pc = $urandom;
            rand_wr(rw);
            tick();
            chk("wait_hold", enable, 1'b0);
            chk("wait_pc", pc, mpc);
        end
        done = 1'b1; pcenable = pcen; next_pc = npc;
        wenable = we; wfmode = wf; wreg = wr; wdata = wd;
        tick();
        mpc = pcen ? npc : mpc + 32'd4;
        done = 1'b0; pcenable = 1'b0; wenable = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        rstn = 1'b0; stop = 1'b0; done = 1'b0; pcenable = 1'b0; next_pc = '0;
        wenable = 1'b0; wfmode = 1'b0; wreg = '0; wdata = '0;
        mpc = RST_PC;
        for (int i = 0; i < (1 << AW); i++) begin
            w = $urandom;
            if (w[31:26] == OP_J) w[31:26] = OP_ADDI;
            imem[i] = w;
        end
        imem[0]  = {OP_ADDI, 5'd3, 5'd0, 16'h0005};
        imem[1]  = {OP_ADDI, 5'd1, 5'd3, 16'h1800};
        imem[16] = {OP_ADDI, 5'd7, 5'd0, 16'h0000};
        imem[17] = {OP_FADD, 5'd1, 5'd0, 16'h0000};
        imem[18] = {OP_FADD, 5'd1, 5'd2, 16'h1000};
        imem[19] = {OP_ITOF, 5'd1, 5'd4, 16'h2800};
        imem[20] = {OP_FTOI, 5'd1, 5'd6, 16'h3800};
        imem[21] = {OP_ADDI, 5'd1, 5'd9, 16'h4800};
        imem[22] = {OP_J, 26'd8};

        // Populate both files while held in reset.
        for (int i = 0; i < 64; i++) begin
            wenable = 1'b1; wfmode = (i >= 32); wreg = 5'(i % 32); wdata = $urandom;
            tick();
        end
        wenable = 1'b0;
        chk("rst_en", enable, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", imem_addr, RST_PC[AW+1:2]);
        chk("rst_op", opecode, OP_J);
        chk("rst_off", offset, 16'h0);
        chk("rst_rd", rd_no, 5'd0);
        chk("rst_rs", rs, 32'd0);
        chk("rst_rt", rt, 32'd0);
        chk("rst_fm1", fmode1, 1'b0);
        chk("rst_fm2", fmode2, 1'b0);

        rstn = 1'b1;
        do_issue(0, 0, 0, 0, 0, 0, 0);
        do_done(0, 0, 0, 1, 0, 5'd3, 32'd5, 0);
        do_issue(0, 0, 0, 0, 0, 0, 0);
        chk("r3_readback", rs, 32'd5);
        // Branch to 0x40 with an ignored r0 write.
        do_done(1, 1, 32'h40, 1, 0, 5'd0, 32'hFFFF_FFFF, 0);
        chk("branch_addr", imem_addr, 15'h10);
        do_issue(0, 0, 0, 0, 0, 0, 0);
        chk("r0_zero", rs, 32'd0);
        do_done(0, 0, 0, 1, 1, 5'd0, 32'h3F80_0000, 0);
        do_issue(0, 0, 0, 0, 0, 0, 0);
        chk("f0_read", rs, 32'h3F80_0000);
        do_done(0, 0, 0, 0, 0, 0, 0, 0);
        do_issue(0, 0, 1, 1, 5'd2, 32'h4000_0000, 0);
        do_done(2, 0, 0, 0, 0, 0, 0, 0);
        do_issue(0, 1, 0, 0, 0, 0, 0);
        do_done(0, 0, 0, 0, 0, 0, 0, 0);
        do_issue(1, 1, 0, 0, 0, 0, 0);
        do_done(0, 0, 0, 0, 0, 0, 0, 0);
        do_issue(3, 0, 0, 0, 0, 0, 1);
        do_done(0, 0, 0, 0, 0, 0, 0, 0);
        do_issue(0, 1, 0, 0, 0, 0, 0);
        // PC wrap.
        do_done(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        do_issue(0, 1, 0, 0, 0, 0, 0);
        do_done(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'd0);
        do_issue(0, 1, 0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_done($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), $urandom, 1);
            do_issue($urandom_range(0, 3), 1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        end

        // Reset while waiting on exec.
        rstn = 1'b0;
        tick();
        mpc = RST_PC;
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_en", enable, 1'b0);
        chk("mid_rst_op", opecode, OP_J);
        rstn = 1'b1;
        do_issue(0, 0, 0, 0, 0, 0, 0);

        imem[8] = {OP_J, 26'd8};
        do_done(0, 1, 32'h20, 0, 0, 0, 0, 0);
        chk("halt_addr", imem_addr, 15'd8);
        tick();
        tick();
        chk("halted", halted, 1'b1);
        chk("halt_en", enable, 1'b0);
        for (int k = 0; k < 6; k++) begin
            done = 1'($urandom_range(0, 1)); pcenable = 1'b1; next_pc = $urandom;
            stop = 1'($urandom_range(0, 1));
            tick();
            chk("halt_hold_en", enable, 1'b0);
            chk("halt_hold_pc", pc, 32'h20);
            chk("halt_hold", halted, 1'b1);
        end
        done = 1'b0; pcenable = 1'b0; stop = 1'b0;
        rstn = 1'b0;
        tick();
        chk("halt_rst", halted, 1'b0);
        chk("halt_rst_pc", pc, RST_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
